multdiv_issue_ctrl: RTL and testbench

Issue/writeback controller for the 17-stage pipelined multiplier/divider unit. It accepts mult/div requests from the processor with a destination register tag and drives one-cycle `ctrl_MULT`/`ctrl_DIV` pulses into the unit. It tracks in-flight destination tags through a shadow pipeline matched to the unit latency, and reports RAW hazards against in-flight and buffered results. Completed results are buffered in a small FIFO and handed to the register-file writeback port via a valid/ready handshake.

---
 rtl/multdiv_pkg.sv | 28 ++
 rtl/multdiv_issue_ctrl_if.sv | 44 ++++
 rtl/md_result_fifo.sv | 61 ++++++
 rtl/multdiv_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue controller.
// Optional build macro: MULTDIV_FLUSH_EN adds a flush input to the top.
package multdiv_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    localparam int   DATA_W  = 32;
    localparam int   REG_W   = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
    } md_tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              exc;
        logic [REG_W-1:0]  dst;
    } md_wb_t;

    // Register 0 is hard-wired, so it can never be a hazard source.
    function automatic logic tag_hit(input logic vld, input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src_a,
                                     input logic [REG_W-1:0] src_b);
        return vld && (((src_a != '0) && (dst == src_a)) || ((src_b != '0) && (dst == src_b)));
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of request, unit, writeback and status signals of the mult/div controller.
// master = controller side, slave = processor/unit/writeback side.
interface multdiv_issue_ctrl_if;
    import multdiv_pkg::*;

    logic              req_valid;
    logic              req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [REG_W-1:0]  req_dst;
    logic              req_ready;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic              hazard;
    logic [DATA_W-1:0] md_operandA;
    logic [DATA_W-1:0] md_operandB;
    logic              md_ctrl_MULT;
    logic              md_ctrl_DIV;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;
    logic              md_resultRDY;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              wb_exc;
    logic [REG_W-1:0]  wb_dst;
    logic              wb_ready;
    logic              busy;
    logic              err_spurious;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_dst, src_a, src_b,
               md_result, md_exception, md_resultRDY, wb_ready,
        output req_ready, hazard, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
               wb_valid, wb_data, wb_exc, wb_dst, busy, err_spurious
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_dst, src_a, src_b,
               md_result, md_exception, md_resultRDY, wb_ready,
        input  req_ready, hazard, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
               wb_valid, wb_data, wb_exc, wb_dst, busy, err_spurious
    );

endinterface

// File: rtl/md_result_fifo.sv
// Result buffer between the mult/div unit and the writeback port.
// Flop-based so every entry's destination is visible to the hazard compare.
module md_result_fifo
    import multdiv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             rs,
    input  logic             push_i,
    input  md_wb_t           push_data_i,
    input  logic             pop_i,
    output md_wb_t           head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic [DEPTH-1:0] entry_vld_o,
    output logic [REG_W-1:0] entry_dst_o [DEPTH]
);

    md_wb_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clock or posedge rs) begin
        if (rs) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset          = PTR_W'(gi) - rd_ptr_q;
        assign entry_vld_o[gi] = ({1'b0, offset} < count_q);
        assign entry_dst_o[gi] = mem_q[gi].dst;
    end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback controller for the pipelined mult/div unit.
// Optional build macro: MULTDIV_FLUSH_EN adds the flush input and result-suppression window.
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic clock,
    input logic rs,
`ifdef MULTDIV_FLUSH_EN
    input logic flush,
`endif
    multdiv_issue_ctrl_if.master bus
);

    localparam int CNT_W  = $clog2(LATENCY + FIFO_DEPTH + 2) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  flush_w;
    logic                  suppress;
    logic                  issue_vld_q, issue_vld_d;
    logic                  issue_op_q, issue_op_d;
    logic [REG_W-1:0]      issue_dst_q, issue_dst_d;
    logic [DATA_W-1:0]     opa_q, opa_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    md_tag_t               pipe_q [LATENCY];
    md_tag_t               head;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      credit;
    logic                  load;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;
    md_wb_t                fifo_in;
    md_wb_t                fifo_head;
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [REG_W-1:0]      fifo_dst [FIFO_DEPTH];
    logic [LATENCY-1:0]    pipe_hit;
    logic [FIFO_DEPTH-1:0] fifo_hit;

`ifdef MULTDIV_FLUSH_EN
    localparam int SUP_W = $clog2(LATENCY + 1);
    logic [SUP_W-1:0] sup_q, sup_d;

    // Results of flushed ops can still emerge for LATENCY cycles; swallow them quietly.
    assign flush_w  = flush;
    assign suppress = (sup_q != '0);

    always_comb begin
        sup_d = sup_q;
        if (flush)             sup_d = SUP_W'(LATENCY);
        else if (sup_q != '0)  sup_d = sup_q - SUP_W'(1);
    end

    always_ff @(posedge clock or posedge rs) begin
        if (rs) sup_q <= '0;
        else    sup_q <= sup_d;
    end
`else
    assign flush_w  = 1'b0;
    assign suppress = 1'b0;
`endif

    always_comb begin
        inflight = CNT_W'(issue_vld_q);
        for (int i = 0; i < LATENCY; i++) inflight = inflight + CNT_W'(pipe_q[i].valid);
    end

    // Credit is purely state-based; a same-cycle pop frees a slot only next cycle.
    assign credit        = inflight + CNT_W'(fifo_count);
    assign bus.req_ready = (credit < CNT_W'(FIFO_DEPTH));
    assign bus.busy      = (credit != '0);
    assign load          = bus.req_valid & bus.req_ready & ~flush_w;

    always_comb begin
        issue_vld_d = load;
        issue_op_d  = issue_op_q;
        issue_dst_d = issue_dst_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        if (load) begin
            issue_op_d  = bus.req_op;
            issue_dst_d = bus.req_dst;
            opa_d       = bus.req_a;
            opb_d       = bus.req_b;
        end
    end

    assign head      = pipe_q[LATENCY-1];
    assign fifo_push = head.valid & bus.md_resultRDY;
    assign fifo_in   = '{data: bus.md_result, exc: bus.md_exception, dst: head.dst};
    assign err_d     = err_q | (head.valid & ~bus.md_resultRDY)
                             | (~head.valid & bus.md_resultRDY & ~suppress);

    always_ff @(posedge clock or posedge rs) begin
        if (rs) begin
            issue_vld_q <= 1'b0;
            issue_op_q  <= OP_MULT;
            issue_dst_q <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            issue_op_q  <= issue_op_d;
            issue_dst_q <= issue_dst_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            err_q       <= err_d;
            pipe_q[0]   <= '{valid: issue_vld_q & ~flush_w, dst: issue_dst_q};
            for (int i = 1; i < LATENCY; i++)
                pipe_q[i] <= '{valid: pipe_q[i-1].valid & ~flush_w, dst: pipe_q[i-1].dst};
        end
    end

    assign bus.md_ctrl_MULT = issue_vld_q & (issue_op_q == OP_MULT);
    assign bus.md_ctrl_DIV  = issue_vld_q & (issue_op_q == OP_DIV);
    assign bus.md_operandA  = opa_q;
    assign bus.md_operandB  = opb_q;
    assign bus.err_spurious = err_q;

    md_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock       (clock),
        .rs          (rs),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .entry_vld_o (fifo_vld),
        .entry_dst_o (fifo_dst)
    );

    assign bus.wb_valid = ~fifo_empty;
    assign bus.wb_data  = fifo_head.data;
    assign bus.wb_exc   = fifo_head.exc;
    assign bus.wb_dst   = fifo_head.dst;
    assign fifo_pop     = bus.wb_valid & bus.wb_ready;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe_hit
        assign pipe_hit[gi] = tag_hit(pipe_q[gi].valid, pipe_q[gi].dst, bus.src_a, bus.src_b);
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_hit
        assign fifo_hit[gi] = tag_hit(fifo_vld[gi], fifo_dst[gi], bus.src_a, bus.src_b);
    end

    assign bus.hazard = (|pipe_hit) | (|fifo_hit)
                      | tag_hit(issue_vld_q, issue_dst_q, bus.src_a, bus.src_b);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomised bench for multdiv_issue_ctrl with an outstanding-op queue as reference.
// Build with MULTDIV_FLUSH_EN defined to also exercise flush.
module tb_multdiv_issue_ctrl;

    localparam int LAT        = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int WB_LAT     = LAT + 2;

    typedef struct {
        logic [31:0] data;
        logic        exc;
        logic [4:0]  dst;
        int          rdy;
    } exp_t;

    logic clock;
    logic rs;
`ifdef MULTDIV_FLUSH_EN
    logic flush;
`endif

    multdiv_issue_ctrl_if bus ();

    multdiv_issue_ctrl dut (
        .clock (clock),
        .rs    (rs),
`ifdef MULTDIV_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        q[$];
    logic        prev_acc;
    logic        prev_op;
    logic [31:0] prev_a, prev_b;
    logic        obs_wbv, obs_exc;
    logic [31:0] obs_data;
    logic [4:0]  obs_dst;

    // Unit behaviour: multiply low word, signed divide, exception on /0 or overflow.
    function automatic logic [32:0] calc(input logic div, input logic [31:0] a, input logic [31:0] b);
        if (!div) return {1'b0, a * b};
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {1'b1, 32'h0};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Unit model: result appears LAT cycles after the ctrl pulse cycle.
    logic        sh_v   [LAT+1];
    logic        sh_exc [LAT+1];
    logic [31:0] sh_d   [LAT+1];

    always @(negedge clock) begin
        logic [32:0] r;
        for (int k = LAT; k > 0; k--) begin
            sh_v[k]   = sh_v[k-1];
            sh_exc[k] = sh_exc[k-1];
            sh_d[k]   = sh_d[k-1];
        end
        r         = calc(bus.md_ctrl_DIV, bus.md_operandA, bus.md_operandB);
        sh_v[0]   = bus.md_ctrl_MULT | bus.md_ctrl_DIV;
        sh_exc[0] = r[32];
        sh_d[0]   = r[31:0];
        bus.md_resultRDY = sh_v[LAT];
        bus.md_exception = sh_exc[LAT];
        bus.md_result    = sh_d[LAT];
    end

    task automatic step(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [4:0] sa, input logic [4:0] sb,
                        input logic wr, input logic fl);
        logic        exp_rdy, exp_wbv, exp_haz, acc;
        logic [32:0] res;
        exp_t        e;
        @(negedge clock);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_dst   = d;
        bus.src_a     = sa;
        bus.src_b     = sb;
        bus.wb_ready  = wr;
`ifdef MULTDIV_FLUSH_EN
        flush = fl;
`endif
        #1;
        exp_rdy = (q.size() < FIFO_DEPTH);
        exp_wbv = (q.size() != 0) && (q[0].rdy <= cyc);
        exp_haz = 1'b0;
        foreach (q[i])
            if ((sa != 5'd0 && q[i].dst == sa) || (sb != 5'd0 && q[i].dst == sb)) exp_haz = 1'b1;
        obs_wbv  = bus.wb_valid;
        obs_data = bus.wb_data;
        obs_exc  = bus.wb_exc;
        obs_dst  = bus.wb_dst;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check_val("busy", 32'(bus.busy), 32'(q.size() != 0));
        check_val("hazard", 32'(bus.hazard), 32'(exp_haz));
        check_val("wb_valid", 32'(obs_wbv), 32'(exp_wbv));
        if (exp_wbv) begin
            check_val("wb_data", obs_data, q[0].data);
            check_val("wb_exc", 32'(obs_exc), 32'(q[0].exc));
            check_val("wb_dst", 32'(obs_dst), 32'(q[0].dst));
        end
        check_val("ctrl_mult", 32'(bus.md_ctrl_MULT), 32'(prev_acc & ~prev_op));
        check_val("ctrl_div", 32'(bus.md_ctrl_DIV), 32'(prev_acc & prev_op));
        if (prev_acc) begin
            check_val("operandA", bus.md_operandA, prev_a);
            check_val("operandB", bus.md_operandB, prev_b);
        end
        check_val("err_spurious", 32'(bus.err_spurious), 32'h0);
        if (exp_wbv && wr) begin
            $display("wb   cyc=%0d dst=%0d data=%08h exc=%0b", cyc, q[0].dst, q[0].data, q[0].exc);
            void'(q.pop_front());
        end
        if (fl) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].rdy > cyc + 1) q.delete(i);
            $display("flsh cyc=%0d outstanding=%0d", cyc, q.size());
        end
        acc = v & exp_rdy & ~fl;
        if (acc) begin
            res    = calc(op, a, b);
            e.data = res[31:0];
            e.exc  = res[32];
            e.dst  = d;
            e.rdy  = cyc + WB_LAT;
            q.push_back(e);
            $display("req  cyc=%0d op=%0b a=%08h b=%08h dst=%0d", cyc, op, a, b, d);
        end
        prev_acc = acc;
        prev_op  = op;
        prev_a   = a;
        prev_b   = b;
        cyc++;
    endtask

    task automatic idle(input int n, input logic wr);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, wr, 1'b0);
    endtask

    task automatic wait_wb(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
            if (obs_wbv) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rs            = 1'b1;
        bus.req_valid = 1'b0;
        bus.wb_ready  = 1'b0;
        bus.src_a     = 5'd9;
        bus.src_b     = 5'd3;
`ifdef MULTDIV_FLUSH_EN
        flush = 1'b0;
`endif
        for (int k = 0; k <= LAT; k++) begin
            sh_v[k]   = 1'b0;
            sh_exc[k] = 1'b0;
            sh_d[k]   = 32'h0;
        end
        q.delete();
        prev_acc = 1'b0;
        #1;
        check_val("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
        check_val("rst_wb_data", bus.wb_data, 32'h0);
        check_val("rst_wb_exc", 32'(bus.wb_exc), 32'h0);
        check_val("rst_wb_dst", 32'(bus.wb_dst), 32'h0);
        check_val("rst_ctrl_mult", 32'(bus.md_ctrl_MULT), 32'h0);
        check_val("rst_ctrl_div", 32'(bus.md_ctrl_DIV), 32'h0);
        check_val("rst_operandA", bus.md_operandA, 32'h0);
        check_val("rst_operandB", bus.md_operandB, 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_err", 32'(bus.err_spurious), 32'h0);
        check_val("rst_hazard", 32'(bus.hazard), 32'h0);
        @(negedge clock);
        rs = 1'b0;
        $display("rst  cyc=%0d", cyc);
    endtask

    initial begin
        int lat;
        logic fl;
        clock = 1'b0;
        rs    = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.req_dst   = 5'd0;
        bus.src_a     = 5'd0;
        bus.src_b     = 5'd0;
        bus.wb_ready  = 1'b0;
`ifdef MULTDIV_FLUSH_EN
        flush = 1'b0;
`endif
        do_reset();

        // Single multiply
        step(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        wait_wb(lat);
        check_val("mul_latency", 32'(lat), 32'd18);
        check_val("mul_data", obs_data, 32'd42);
        check_val("mul_dst", 32'(obs_dst), 32'd3);
        check_val("mul_exc", 32'(obs_exc), 32'd0);
        idle(3, 1'b1);

        // Divide by zero
        step(1'b1, 1'b1, 32'd10, 32'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
        wait_wb(lat);
        check_val("div0_exc", 32'(obs_exc), 32'd1);
        check_val("div0_dst", 32'(obs_dst), 32'd5);
        idle(3, 1'b1);

        // Back-to-back fill, held fifth op, then drain
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'(k % 2), 32'(100 + k), 32'(3 + k), 5'(10 + k), 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++)
            step(1'b1, 1'b0, 32'd55, 32'd2, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0);
        check_val("b2b_ready_low", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 32'd55, 32'd2, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(25, 1'b1);

        // Hazard against dst 9 until popped; dst 0 never hazards
        step(1'b1, 1'b0, 32'd3, 32'd3, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 22; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'd4, 32'd4, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int k = 0; k < 22; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);

        // Reset mid-flight
        step(1'b1, 1'b0, 32'd9, 32'd9, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(8, 1'b1);
        do_reset();
        idle(25, 1'b1);

`ifdef MULTDIV_FLUSH_EN
        // Flush two in-flight ops, then a fresh op writes back
        step(1'b1, 1'b0, 32'd2, 32'd8, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'd81, 32'd9, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        idle(25, 1'b1);
        step(1'b1, 1'b0, 32'd5, 32'd5, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0);
        wait_wb(lat);
        check_val("post_flush_data", obs_data, 32'd25);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [31:0] b;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            fl = 1'b0;
`ifdef MULTDIV_FLUSH_EN
            fl = ($urandom_range(0, 29) == 0);
`endif
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom, b,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) < 7), fl);
        end
        idle(30, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
